// File: rtl/sseg_mux.sv
// Four-digit multiplexed seven-segment driver with ghost-suppression blanking,
// frame-atomic shadow registers and optional leading-zero blanking.
module sseg_mux #(
  parameter int REFRESH_DVSR = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [7:0]  sseg,
  output logic        dbg_state
);

  localparam logic [23:0] SLOT_LAST  = 24'(REFRESH_DVSR - 1);
  localparam logic [23:0] BLANK_LAST = 24'(BLANK_CYCLES - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [23:0] cnt;
  logic [1:0]  idx;
  logic [15:0] sh_digits;
  logic [3:0]  sh_dp;
  logic        slot_end;
  logic        frame_end;
  logic [3:0]  nibble;
  logic        blanked;
  logic [6:0]  seg7;
  logic [3:0]  an_next;
  logic [7:0]  sseg_next;

  assign slot_end  = (cnt == SLOT_LAST);
  assign frame_end = slot_end && (idx == 2'd3);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      idx   <= '0;
      state <= ST_BLANK;
    end else begin
      cnt   <= slot_end ? '0 : cnt + 24'd1;
      if (slot_end) idx <= idx + 2'd1;
      state <= state_next;
    end
  end

  // Shadow only changes between frames so one frame never mixes two inputs.
  always_ff @(posedge clk) begin
    if (reset || frame_end) begin
      sh_digits <= digits;
      sh_dp     <= dp_in;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_BLANK: if (cnt == BLANK_LAST) state_next = ST_SHOW;
      ST_SHOW:  if (slot_end)          state_next = ST_BLANK;
      default:                         state_next = ST_BLANK;
    endcase
  end

  always_comb begin
    nibble  = sh_digits[{idx, 2'b00} +: 4];
    blanked = 1'b0;
    case (idx)
      2'd3:    blanked = blank_lz && (sh_digits[15:12] == 4'h0);
      2'd2:    blanked = blank_lz && (sh_digits[15:8]  == 8'h00);
      2'd1:    blanked = blank_lz && (sh_digits[15:4]  == 12'h000);
      default: blanked = 1'b0;
    endcase
  end

  // Active-low {g,f,e,d,c,b,a}; non-BCD values render as a dash.
  always_comb begin
    case (nibble)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h3F;
    endcase
  end

  always_comb begin
    an_next   = 4'hF;
    sseg_next = 8'hFF;
    if (state == ST_SHOW && !blanked) begin
      an_next   = ~(4'b0001 << idx);
      sseg_next = {~sh_dp[idx], seg7};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an   <= 4'hF;
      sseg <= 8'hFF;
    end else begin
      an   <= an_next;
      sseg <= sseg_next;
    end
  end

endmodule

// File: tb/tb_sseg_mux.sv
// Directed bench for sseg_mux (REFRESH_DVSR=8, BLANK_CYCLES=2): the driver queues
// the expected {an,sseg} per clock edge, a monitor pops and compares on negedge.
module tb_sseg_mux;

  localparam int W = 44;  // {target_edge[31:0], an[3:0], sseg[7:0]}

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        dbg_state;

  logic [W-1:0] exp_q[$];
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  string cur_test = "init";

  sseg_mux #(.REFRESH_DVSR(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .digits(digits), .dp_in(dp_in),
    .blank_lz(blank_lz), .an(an), .sseg(sseg), .dbg_state(dbg_state)
  );

  // ---------------- clock / edge counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      if (int'(e[43:12]) < cyc) begin
        void'(exp_q.pop_front());
        n_checks++;
        $display("FAIL %s stale_entry edge=%0d now=%0d", cur_test, e[43:12], cyc);
      end else if (int'(e[43:12]) == cyc) begin
        void'(exp_q.pop_front());
        n_checks++;
        if (an === e[11:8] && sseg === e[7:0]) n_pass++;
        else $display("FAIL %s edge=%0d an=%b sseg=%h expected an=%b sseg=%h",
                      cur_test, cyc, an, sseg, e[11:8], e[7:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [3:0] ea, input logic [7:0] es);
    exp_q.push_back({32'(cyc + 1), ea, es});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) step(4'hF, 8'hFF);
    reset = 1'b0;
  endtask

  // sg byte k / on bit k describe digit k; frame 0 uses sg0/on0, later frames sg1/on1.
  task automatic run(input int ncyc, input logic [31:0] sg0, input logic [3:0] on0,
                     input logic [31:0] sg1, input logic [3:0] on1,
                     input int chg_at, input logic [15:0] chg_digits);
    int c, s, f;
    logic [31:0] sg;
    logic [3:0]  on;
    logic [3:0]  a;
    for (int t = 1; t <= ncyc; t++) begin
      if (t == chg_at) digits = chg_digits;
      c  = (t - 1) % 8;
      s  = ((t - 1) / 8) % 4;
      f  = (t - 1) / 32;
      sg = (f == 0) ? sg0 : sg1;
      on = (f == 0) ? on0 : on1;
      if (c < 2 || !on[s]) begin
        step(4'hF, 8'hFF);
      end else begin
        a = 4'b0001 << s;
        step(~a, sg[s*8 +: 8]);
      end
    end
  endtask

  task automatic setup(input string name, input logic [15:0] d, input logic [3:0] dp,
                       input logic lz);
    cur_test = name;
    digits   = d;
    dp_in    = dp;
    blank_lz = lz;
    do_reset(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b1;
    digits   = 16'h0;
    dp_in    = 4'h0;
    blank_lz = 1'b0;
    @(posedge clk);
    #1;

    setup("scan_1234", 16'h1234, 4'h0, 1'b0);
    run(64, 32'hF9A4B099, 4'hF, 32'hF9A4B099, 4'hF, 0, 16'h0);

    setup("lz_0009", 16'h0009, 4'h0, 1'b1);
    run(64, 32'hFFFFFF90, 4'b0001, 32'hFFFFFFC0, 4'b0001, 5, 16'h0000);

    setup("lz_0305", 16'h0305, 4'h0, 1'b1);
    run(32, 32'hFFB0C092, 4'b0111, 32'hFFB0C092, 4'b0111, 0, 16'h0);

    setup("lz_0050", 16'h0050, 4'h0, 1'b1);
    run(32, 32'hFFFF92C0, 4'b0011, 32'hFFFF92C0, 4'b0011, 0, 16'h0);

    setup("dash_00A5", 16'h00A5, 4'h0, 1'b0);
    run(32, 32'hC0C0BF92, 4'hF, 32'hC0C0BF92, 4'hF, 0, 16'h0);

    setup("dp_5959", 16'h5959, 4'b0100, 1'b0);
    run(32, 32'h92109290, 4'hF, 32'h92109290, 4'hF, 0, 16'h0);

    setup("frame_atomic", 16'h1111, 4'h0, 1'b0);
    run(64, 32'hF9F9F9F9, 4'hF, 32'hA4A4A4A4, 4'hF, 12, 16'h2222);

    setup("reset_abort", 16'h1234, 4'h0, 1'b0);
    run(20, 32'hF9A4B099, 4'hF, 32'hF9A4B099, 4'hF, 0, 16'h0);
    do_reset(1);
    run(40, 32'hF9A4B099, 4'hF, 32'hF9A4B099, 4'hF, 0, 16'h0);

    cur_test = "drain";
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d expected pending=0", exp_q.size());
    end
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
